// File: rtl/soc_event_queue_pkg.sv
// Shared types and constants for the event queue block (package soc_evt_pkg).
package soc_evt_pkg;

  localparam int OVF_CNT_WIDTH        = 16;
  localparam int EVT_ID_WIDTH_DEFAULT = 8;

  typedef logic [EVT_ID_WIDTH_DEFAULT-1:0] evt_id_t;

endpackage

// File: rtl/soc_event_queue_if.sv
// Valid/ready stream bundle used for the queue's push and pop sides.
interface soc_event_queue_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/soc_event_queue_fifo.sv
// Power-of-two FIFO for event IDs (module soc_evt_fifo); head reads as zero when empty.
module soc_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  soc_event_queue_if.slave  push,
  soc_event_queue_if.master pop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push.ready = (count != (AW+1)'(DEPTH));
  assign pop.valid  = (count != '0);
  assign pop.data   = pop.valid ? mem[rd_ptr] : '0;
  assign do_push    = push.valid & push.ready;
  assign do_pop     = pop.valid & pop.ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push.data;
  end

endmodule

// File: rtl/soc_event_queue.sv
// Event pulse collector: pending flags, round-robin grant into a FIFO of source IDs.
// Overflow status ports exist only when SOC_EVT_OVERFLOW_STATUS_EN is defined.
module soc_event_queue
  import soc_evt_pkg::*;
#(
  parameter int NB_SOURCES     = 32,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_SOURCES-1:0]     evt_i,
  output logic                      evt_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
  input  logic                      evt_ready_i,
  output logic [NB_SOURCES-1:0]     pending_o
`ifdef SOC_EVT_OVERFLOW_STATUS_EN
  ,
  input  logic                      clr_ovf_i,
  output logic                      overflow_o,
  output logic [OVF_CNT_WIDTH-1:0]  ovf_cnt_o
`endif
);

  localparam int PW = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1;

  logic [NB_SOURCES-1:0] pending;
  logic [PW-1:0]         rr_ptr;
  logic                  grant;
  logic [PW-1:0]         gnt_idx;
  logic [NB_SOURCES-1:0] gnt_onehot;
  int unsigned           idx;

  soc_event_queue_if #(.WIDTH(EVENT_ID_WIDTH)) push_if ();
  soc_event_queue_if #(.WIDTH(EVENT_ID_WIDTH)) pop_if ();

  // Scan from the farthest offset down so the source nearest rr_ptr wins.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = NB_SOURCES - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NB_SOURCES;
      if (pending[idx]) begin
        grant   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    grant = grant & push_if.ready;
  end

  assign gnt_onehot     = grant ? (NB_SOURCES'(1) << gnt_idx) : '0;
  assign push_if.valid  = grant;
  assign push_if.data   = EVENT_ID_WIDTH'(gnt_idx);
  assign pop_if.ready   = evt_ready_i;
  assign evt_valid_o    = pop_if.valid;
  assign evt_data_o     = pop_if.data;
  assign pending_o      = pending;

  // A pulse on the source being granted re-arms it rather than being lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending & ~gnt_onehot) | evt_i;
      if (grant) rr_ptr <= (gnt_idx == PW'(NB_SOURCES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  soc_evt_fifo #(
    .WIDTH (EVENT_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_if),
    .pop   (pop_if)
  );

`ifdef SOC_EVT_OVERFLOW_STATUS_EN
  logic [NB_SOURCES-1:0]    lost;
  logic [OVF_CNT_WIDTH-1:0] cnt_base;
  logic [OVF_CNT_WIDTH:0]   cnt_sum;
  logic                     overflow;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;

  assign lost     = evt_i & pending & ~gnt_onehot;
  assign cnt_base = clr_ovf_i ? '0 : ovf_cnt;
  assign cnt_sum  = {1'b0, cnt_base} + (OVF_CNT_WIDTH+1)'($countones(lost));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      overflow <= (overflow & ~clr_ovf_i) | (|lost);
      ovf_cnt  <= cnt_sum[OVF_CNT_WIDTH] ? '1 : cnt_sum[OVF_CNT_WIDTH-1:0];
    end
  end

  assign overflow_o = overflow;
  assign ovf_cnt_o  = ovf_cnt;
`endif

endmodule

// File: tb/tb_soc_event_queue.sv
// Scoreboard bench for soc_event_queue: directed scenarios then random traffic vs a queue model.
module tb_soc_event_queue;
  import soc_evt_pkg::*;

  localparam int NS    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] evt;
  logic [NS-1:0] pending;
  logic          clr;

  soc_event_queue_if #(.WIDTH(8)) out_if ();

`ifdef SOC_EVT_OVERFLOW_STATUS_EN
  logic        overflow;
  logic [15:0] ovf_cnt;
`endif

  soc_event_queue #(
    .NB_SOURCES     (NS),
    .EVENT_ID_WIDTH (8),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .evt_valid_o (out_if.valid),
    .evt_data_o  (out_if.data),
    .evt_ready_i (out_if.ready),
    .pending_o   (pending)
`ifdef SOC_EVT_OVERFLOW_STATUS_EN
    ,
    .clr_ovf_i   (clr),
    .overflow_o  (overflow),
    .ovf_cnt_o   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, round-robin pointer and queue occupancy as plain variables.
  bit      m_pend [NS];
  int      m_rr;
  int      m_count;
  evt_id_t sb_q [$];
  bit      started = 0;
  int      m_ovf;
  int      m_cnt;

  always @(posedge clk) begin
    int granted;
    int nlost;
    bit popped;
    started <= 1'b1;
    if (rst) begin
      foreach (m_pend[k]) m_pend[k] = 0;
      m_rr    = 0;
      m_count = 0;
      m_ovf   = 0;
      m_cnt   = 0;
      sb_q.delete();
    end else begin
      granted = -1;
      if (m_count < DEPTH) begin
        for (int i = 0; i < NS; i++) begin
          if (granted < 0 && m_pend[(m_rr + i) % NS]) granted = (m_rr + i) % NS;
        end
      end
      popped = (m_count > 0) && out_if.ready;
      nlost  = 0;
      for (int k = 0; k < NS; k++) if (evt[k] && m_pend[k] && k != granted) nlost++;
      if (clr) begin
        m_ovf = 0;
        m_cnt = 0;
      end
      if (nlost > 0) m_ovf = 1;
      m_cnt = (m_cnt + nlost > 16'hFFFF) ? 16'hFFFF : m_cnt + nlost;
      if (granted >= 0) begin
        sb_q.push_back(evt_id_t'(granted));
        m_pend[granted] = 0;
        m_rr = (granted + 1) % NS;
        m_count++;
      end
      if (popped) m_count--;
      for (int k = 0; k < NS; k++) if (evt[k]) m_pend[k] = 1;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    logic [NS-1:0] exp_pend;
    if (started) begin
      for (int k = 0; k < NS; k++) exp_pend[k] = m_pend[k];
      check("valid", 64'(out_if.valid), 64'(m_count > 0));
      check("pending", 64'(pending), 64'(exp_pend));
`ifdef SOC_EVT_OVERFLOW_STATUS_EN
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
`endif
      if (out_if.valid && sb_q.size() > 0) begin
        check("head", 64'(out_if.data), 64'(sb_q[0]));
        if (out_if.ready) begin
          void'(sb_q.pop_front());
          n_deliv++;
        end
      end
    end
  end

  task automatic step(input logic [NS-1:0] e, input logic r, input logic c);
    evt          = e;
    out_if.ready = r;
    clr          = c;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    logic [NS-1:0] e;
    rst          = 1'b1;
    evt          = '0;
    clr          = 1'b0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_data", 64'(out_if.data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    rst = 1'b0;

    // Single pulse on source 5: visible two cycles later for exactly one cycle.
    step(NS'(1) << 5, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("single_valid", 64'(out_if.valid), 64'd1);
    check("single_data", 64'(out_if.data), 64'd5);
    step('0, 1'b1, 1'b0);
    check("single_gone", 64'(out_if.valid), 64'd0);

    // Round-robin from pointer 0.
    do_reset();
    step((NS'(1) << 0) | (NS'(1) << 3) | (NS'(1) << 31), 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("rr_first", 64'(out_if.data), 64'd0);
    step('0, 1'b1, 1'b0);
    check("rr_second", 64'(out_if.data), 64'd3);
    step('0, 1'b1, 1'b0);
    check("rr_third", 64'(out_if.data), 64'd31);
    step('0, 1'b1, 1'b0);
    check("rr_done", 64'(out_if.valid), 64'd0);

    // Backpressure: six sources, four fit, two stay pending.
    do_reset();
    e = (NS'(1) << 1) | (NS'(1) << 4) | (NS'(1) << 9) | (NS'(1) << 12) | (NS'(1) << 20) | (NS'(1) << 25);
    step(e, 1'b0, 1'b0);
    repeat (8) step('0, 1'b0, 1'b0);
    check("bp_head_held", 64'(out_if.data), 64'd1);
    check("bp_left_pending", 64'(pending), 64'((NS'(1) << 20) | (NS'(1) << 25)));
    d0 = n_deliv;
    repeat (12) step('0, 1'b1, 1'b0);
    check("bp_delivered", 64'(n_deliv - d0), 64'd6);

    // Overflow: fill the queue, pulse source 2 twice while it cannot be granted.
    step((NS'(1) << 10) | (NS'(1) << 11) | (NS'(1) << 12) | (NS'(1) << 13), 1'b0, 1'b0);
    repeat (6) step('0, 1'b0, 1'b0);
    step(NS'(1) << 2, 1'b0, 1'b0);
    step(NS'(1) << 2, 1'b0, 1'b0);
    check("ovf_pending", 64'(pending), 64'(NS'(1) << 2));
`ifdef SOC_EVT_OVERFLOW_STATUS_EN
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(ovf_cnt), 64'd1);
    step('0, 1'b0, 1'b1);
    check("ovf_clr_flag", 64'(overflow), 64'd0);
    check("ovf_clr_count", 64'(ovf_cnt), 64'd0);
`endif
    d0 = n_deliv;
    repeat (10) step('0, 1'b1, 1'b0);
    check("ovf_delivered", 64'(n_deliv - d0), 64'd5);

    // Grant collision on source 7.
    step(NS'(1) << 7, 1'b1, 1'b0);
    d0 = n_deliv;
    step(NS'(1) << 7, 1'b1, 1'b0);
    check("coll_pending", 64'(pending[7]), 64'd1);
    check("coll_data", 64'(out_if.data), 64'd7);
    repeat (5) step('0, 1'b1, 1'b0);
    check("coll_delivered", 64'(n_deliv - d0), 64'd2);

    // Mid-operation reset with three queued entries; evt_i ignored in the reset cycle.
    step((NS'(1) << 1) | (NS'(1) << 2) | (NS'(1) << 3), 1'b0, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0);
    check("mid_queued", 64'(out_if.valid), 64'd1);
    rst = 1'b1;
    step('1, 1'b0, 1'b0);
    rst = 1'b0;
    check("mid_valid", 64'(out_if.valid), 64'd0);
    check("mid_pending", 64'(pending), 64'd0);
    d0 = n_deliv;
    repeat (4) step('0, 1'b1, 1'b0);
    check("mid_nothing", 64'(n_deliv - d0), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      e   = $urandom & $urandom & $urandom & $urandom;
      step(e, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    rst = 1'b0;
    repeat (60) step('0, 1'b1, 1'b0);
    check("drain_valid", 64'(out_if.valid), 64'd0);
    check("drain_sb", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_event_queue.md
SOC_EVENT_QUEUE -- requirements
Module: soc_event_queue

Interface
REQ-001 SHALL have parameter NB_SOURCES, default 32, meaning the number of event pulse sources, with a legal range of 2..2**EVENT_ID_WIDTH.
REQ-002 SHALL have parameter EVENT_ID_WIDTH, default 8, meaning the width of the event ID presented downstream.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queue entries, a power of two and at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port evt_i, input, NB_SOURCES bits: one-cycle event pulses, one bit per source.
REQ-007 SHALL have port evt_valid_o, output, 1 bit: the queue head is valid.
REQ-008 SHALL have port evt_data_o, output, EVENT_ID_WIDTH bits: the source index of the queue head, zero-extended.
REQ-009 SHALL have port evt_ready_i, input, 1 bit: the consumer accepts the head; this is the level-interrupt converter's ready (fulln) signal.
REQ-010 SHALL have port pending_o, output, NB_SOURCES bits: per-source pending flags, for debug.
REQ-011 SHALL have port clr_ovf_i, input, 1 bit: clears the overflow status (present only with the macro of REQ-028).
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky lost-event flag (present only with the macro of REQ-028).
REQ-013 SHALL have port ovf_cnt_o, output, 16 bits: saturating count of lost events (present only with the macro of REQ-028).

Function
REQ-014 SHALL set pending[k] at the clock edge following any cycle in which evt_i[k]=1.
REQ-015 SHALL grant at most one pending source per cycle, round-robin, starting the search at rr_ptr and only when FIFO occupancy < FIFO_DEPTH.
REQ-016 SHALL, on grant of source k: push k into the FIFO, clear pending[k] (unless evt_i[k]=1 in that cycle, in which case it stays set), and set rr_ptr to (k+1) mod NB_SOURCES.
REQ-017 SHALL evaluate full before any same-cycle pop; no push occurs when the FIFO is full, even if a pop happens in that cycle.
REQ-018 SHALL drive evt_valid_o = FIFO not empty; pop occurs on evt_valid_o & evt_ready_i.
REQ-019 SHALL hold evt_data_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-020 SHALL have a minimum latency of 2 cycles: pulse in cycle t -> pending in t+1 -> evt_valid_o with the ID in t+2, given an empty FIFO and no competing source.
REQ-021 SHALL allow push and pop in the same cycle on a non-full, non-empty FIFO, leaving occupancy unchanged.
REQ-022 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH, with occupancy tracked by a counter of width $clog2(FIFO_DEPTH)+1.
REQ-023 SHALL treat evt_i[k]=1 while pending[k]=1 and k is not granted in that cycle as a lost event, with no additional queue entry.
REQ-024 SHALL, for a lost event under the macro of REQ-028: set overflow_o and increment ovf_cnt_o, saturating at 16'hFFFF.
REQ-025 SHALL, under the macro of REQ-028, on clr_ovf_i: clear overflow_o and ovf_cnt_o; if a lost event occurs in the same cycle, the result is ovf_cnt_o=1 and overflow_o=1.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge: pending=0, rr_ptr=0, FIFO empty (evt_valid_o=0, evt_data_o=0), overflow_o=0, ovf_cnt_o=0.
REQ-027 SHALL discard FIFO contents and pending flags on a reset mid-operation, and ignore evt_i during the reset cycle.

Configuration
REQ-028 SHALL compile in the overflow status logic (clr_ovf_i, overflow_o, ovf_cnt_o) only when SOC_EVT_OVERFLOW_STATUS_EN is defined; otherwise those ports and counters are absent and lost events are silently dropped.

Structure
REQ-029 SHALL place in a shared package soc_evt_pkg: the localparam OVF_CNT_WIDTH=16 and the typedef evt_id_t (logic [EVENT_ID_WIDTH-1:0] with default width 8).
REQ-030 SHALL implement the queue as one sub-module, soc_evt_fifo (parameterised by width and depth, with push/pop/full/empty/head).
REQ-031 SHALL keep the round-robin arbiter and pending logic inline in soc_event_queue.

Verification
REQ-032 SHALL verify single pulse: evt_i[5] pulse at t, evt_ready_i=1 -> evt_valid_o=1 with evt_data_o=8'd5 at t+2, for exactly one cycle.
REQ-033 SHALL verify round-robin fairness: evt_i[0], evt_i[3] and evt_i[31] all pulsed in the same cycle with rr_ptr=0 -> IDs output in order 0, 3, 31 on consecutive cycles.
REQ-034 SHALL verify backpressure: evt_ready_i=0 and pulses on 6 distinct sources -> 4 IDs queued with data held stable and 2 sources remaining pending; on release, all 6 IDs are delivered.
REQ-035 SHALL verify overflow: evt_i[2] pulsed twice while blocked -> one ID 2 delivered, overflow_o=1, ovf_cnt_o=1; clr_ovf_i -> both cleared.
REQ-036 SHALL verify grant collision: evt_i[7] pulsed in the same cycle source 7 is granted -> pending[7] remains 1, ID 7 is delivered twice, and no overflow is flagged.
REQ-037 SHALL verify mid-operation reset: rst_i asserted with 3 entries queued -> evt_valid_o=0 and pending_o=0 on the next cycle.
